// File: rtl/serial_logical_or.sv
// Bit-serial logical OR: accepts two N-bit operands over a valid/ready port,
// scans them W bits per cycle and returns (|a || |b) over a valid/ready port.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high (one cycle after reset release)
// SCAN  | consuming W bits of each operand per cycle into the accumulator
// DONE  | result held on c with out_valid high until out_ready
module serial_logical_or #(
  parameter int N          = 8,
  parameter int W          = 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         c,
  output logic         busy
);

  localparam int CHUNKS = N / W;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  if ((N < 1) || (W < 1) || (N % W != 0)) begin : g_bad_params
    $error("serial_logical_or: N must be >= 1 and a multiple of W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic          acc;
  logic [CW-1:0] cnt;
  logic          chunk;
  logic          acc_next;
  logic          scan_end;

  // OR of the current low chunk of both operands and the running result
  assign chunk    = (|a_sh[W-1:0]) | (|b_sh[W-1:0]);
  assign acc_next = acc | chunk;
  // Terminal compare happens before any increment, so cnt never wraps
  assign scan_end = (cnt == LAST) || ((EARLY_EXIT != 0) && acc_next);

  // Single FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      c         <= 1'b0;
      busy      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            acc      <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          acc  <= acc_next;
          a_sh <= a_sh >> W;
          b_sh <= b_sh >> W;
          if (scan_end) begin
            out_valid <= 1'b1;
            c         <= acc_next;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            c         <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_logical_or.sv
// Bench for serial_logical_or: five instances covering W=1/4/8 and both
// EARLY_EXIT settings, directed vectors, reset corner cases and random ops.
module tb_serial_logical_or;

  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid_s  [NI];
  logic       in_ready_s  [NI];
  logic       out_valid_s [NI];
  logic       out_ready_s [NI];
  logic       c_s         [NI];
  logic       busy_s      [NI];
  logic [7:0] a_s         [NI];
  logic [7:0] b_s         [NI];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WG = (g < 2) ? 1 : ((g < 4) ? 4 : 8);
    localparam int EG = (g == 1 || g == 2 || g == 4) ? 1 : 0;
    serial_logical_or #(.N(8), .W(WG), .EARLY_EXIT(EG)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .a         (a_s[g]),
      .b         (b_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .c         (c_s[g]),
      .busy      (busy_s[g])
    );
  end

  function automatic int w_of(input int idx);
    return (idx < 2) ? 1 : ((idx < 4) ? 4 : 8);
  endfunction

  function automatic int ee_of(input int idx);
    return (idx == 1 || idx == 2 || idx == 4) ? 1 : 0;
  endfunction

  // Reference: result is plain nonzero test, latency from first nonzero chunk
  function automatic int model_c(input logic [7:0] av, input logic [7:0] bv);
    return ((av != 0) || (bv != 0)) ? 1 : 0;
  endfunction

  function automatic int model_lat(input int idx, input logic [7:0] av, input logic [7:0] bv);
    int w = w_of(idx);
    int n = 8 / w;
    int mask = (1 << w) - 1;
    int ai = int'(av);
    int bi = int'(bv);
    if (ee_of(idx) == 0) return n;
    for (int i = 0; i < n; i++) begin
      if ((((ai >> (i * w)) & mask) != 0) || (((bi >> (i * w)) & mask) != 0)) return i + 1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Wait (bounded) for in_ready, then present operands for one accept edge
  task automatic start_op(input int idx, input logic [7:0] av, input logic [7:0] bv);
    int waited = 0;
    while (in_ready_s[idx] !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk($sformatf("in_ready_wait[%0d]", idx), int'(in_ready_s[idx] === 1'b1), 1);
    in_valid_s[idx] = 1'b1;
    a_s[idx] = av;
    b_s[idx] = bv;
    @(posedge clk); #1;
    in_valid_s[idx] = 1'b0;
    a_s[idx] = 8'($urandom);
    b_s[idx] = 8'($urandom);
  endtask

  task automatic run_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                        input int gap, input int exp_c, input int exp_lat, input bit noisy);
    int lat;
    bit ok;
    out_ready_s[idx] = (noisy && gap == 0) ? 1'($urandom) : 1'b0;
    start_op(idx, av, bv);
    chk($sformatf("busy_after_accept[%0d]", idx), int'(busy_s[idx]), 1);
    chk($sformatf("in_ready_while_busy[%0d]", idx), int'(in_ready_s[idx]), 0);
    lat = 0;
    while (lat < 40) begin
      if (out_valid_s[idx] === 1'b1) break;
      if (noisy) begin
        in_valid_s[idx] = 1'($urandom);
        a_s[idx] = 8'($urandom);
        b_s[idx] = 8'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("latency[%0d]", idx), lat, exp_lat);
    chk($sformatf("result_c[%0d]", idx), int'(c_s[idx]), exp_c);
    ok = 1'b1;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      if (!(out_valid_s[idx] === 1'b1 && c_s[idx] === 1'(exp_c))) ok = 1'b0;
    end
    if (gap > 0) chk($sformatf("hold_stable[%0d]", idx), int'(ok), 1);
    in_valid_s[idx] = 1'b0;
    out_ready_s[idx] = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("out_valid_drop[%0d]", idx), int'(out_valid_s[idx]), 0);
    chk($sformatf("in_ready_back[%0d]", idx), int'(in_ready_s[idx]), 1);
    chk($sformatf("busy_clear[%0d]", idx), int'(busy_s[idx]), 0);
    chk($sformatf("c_clear[%0d]", idx), int'(c_s[idx]), 0);
    out_ready_s[idx] = noisy ? 1'($urandom) : 1'b0;
    @(posedge clk); #1;
    chk($sformatf("single_transfer[%0d]", idx), int'(out_valid_s[idx]), 0);
    out_ready_s[idx] = 1'b0;
  endtask

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    int         gap;
    int         exp_c;
    int         exp_lat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int  cnt_ov;
    int  idx;
    int  sel;
    int  gap;
    logic [7:0] av, bv;

    vecs[0]  = '{0, 8'h00, 8'h00, 0, 0, 8};
    vecs[1]  = '{1, 8'h04, 8'h00, 0, 1, 3};
    vecs[2]  = '{0, 8'h04, 8'h00, 0, 1, 8};
    vecs[3]  = '{2, 8'h00, 8'h80, 5, 1, 2};
    vecs[4]  = '{4, 8'h01, 8'h00, 1, 1, 1};
    vecs[5]  = '{4, 8'h00, 8'h00, 0, 0, 1};
    vecs[6]  = '{1, 8'h00, 8'h00, 2, 0, 8};
    vecs[7]  = '{1, 8'h80, 8'h00, 0, 1, 8};
    vecs[8]  = '{1, 8'h00, 8'h01, 0, 1, 1};
    vecs[9]  = '{3, 8'h01, 8'h00, 0, 1, 2};
    vecs[10] = '{2, 8'h10, 8'h00, 0, 1, 2};
    vecs[11] = '{2, 8'h00, 8'h03, 0, 1, 1};

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b0;
      a_s[i] = '0;
      b_s[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_in_ready[%0d]", i), int'(in_ready_s[i]), 0);
      chk($sformatf("rst_out_valid[%0d]", i), int'(out_valid_s[i]), 0);
      chk($sformatf("rst_c[%0d]", i), int'(c_s[i]), 0);
      chk($sformatf("rst_busy[%0d]", i), int'(busy_s[i]), 0);
    end
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", int'(in_ready_s[0]), 0);
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("in_ready_after_release[%0d]", i), int'(in_ready_s[i]), 1);

    // Directed table
    for (int v = 0; v < 12; v++)
      run_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].gap,
             vecs[v].exp_c, vecs[v].exp_lat, 1'b0);

    // Reset during SCAN discards the operation
    start_op(0, 8'hFF, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midscan_rst_out_valid", int'(out_valid_s[0]), 0);
    chk("midscan_rst_busy", int'(busy_s[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt_ov = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid_s[0] === 1'b1) cnt_ov++;
    end
    chk("midscan_rst_no_pulse", cnt_ov, 0);
    run_op(0, 8'h00, 8'h00, 0, 0, 8, 1'b0);

    // Reset during DONE discards the held result
    start_op(2, 8'h01, 8'h00);
    @(posedge clk); #1;
    chk("middone_reached", int'(out_valid_s[2]), 1);
    rst_n = 1'b0;
    #1;
    chk("middone_rst_out_valid", int'(out_valid_s[2]), 0);
    chk("middone_rst_c", int'(c_s[2]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt_ov = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid_s[2] === 1'b1) cnt_ov++;
    end
    chk("middone_rst_no_pulse", cnt_ov, 0);

    // Random ops against the reference model
    for (int k = 0; k < 1000; k++) begin
      idx = $urandom_range(0, NI - 1);
      sel = $urandom_range(0, 3);
      av = 8'($urandom);
      bv = 8'($urandom);
      case (sel)
        0: begin av = '0; bv = '0; end
        1: begin av = 8'(1 << $urandom_range(0, 7)); bv = '0; end
        2: begin av = '0; bv = 8'(1 << $urandom_range(0, 7)); end
        default: ;
      endcase
      gap = $urandom_range(0, 3);
      run_op(idx, av, bv, gap, model_c(av, bv), model_lat(idx, av, bv), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
